lzc_scan: RTL and testbench

Multi-cycle leading-zero counter that sits directly upstream of the FMA normalize stage. It accepts the wide un-normalized adder result (3*(SIG_WIDTH+1)+6 bits) together with its pre-normalization exponent. It scans the result MSB-first, one CHUNK-bit slice per cycle, and hands the operand, the exponent and the 7-bit shift count `num` to the normalizer over a valid/ready handshake. Trading latency for area avoids a full 78-bit priority encoder in one cycle.

---
 rtl/lzc_scan.sv | 126 ++++++++++++
 tb/tb_lzc_scan.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lzc_scan.sv
// rtl/lzc_scan.sv - multi-cycle MSB-first leading-zero counter ahead of the FMA normalizer
// Scans one CHUNK-bit slice per cycle; one operand in flight, results held until accepted.
module lzc_scan #(
  parameter int SIG_WIDTH = 23,
  parameter int EXP_WIDTH = 8,
  parameter int CHUNK     = 8,
  localparam int W        = 3 * (SIG_WIDTH + 1) + 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_data,
  input  logic [EXP_WIDTH-1:0] in_exp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic [EXP_WIDTH-1:0] out_exp,
  output logic [6:0]           num,
  output logic                 zero
);

  localparam int NCHUNK = (W + CHUNK - 1) / CHUNK;
  localparam int BUFW   = NCHUNK * CHUNK;
  localparam int PADW   = BUFW - W;
  localparam int IDXW   = $clog2(NCHUNK + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [BUFW-1:0]        r_buf;
  logic [IDXW-1:0]        r_idx;
  logic [6:0]             r_base;
  logic [6:0]             r_num;
  logic                   r_zero;
  logic [W-1:0]           r_out_data;
  logic [EXP_WIDTH-1:0]   r_out_exp;

  logic                   w_accept;
  logic [CHUNK-1:0]       w_chunk;
  logic                   w_chunk_nz;
  logic                   w_last;
  logic [6:0]             w_chunk_lz;

  assign in_ready   = (r_state == S_IDLE) && !rst;
  assign w_accept   = in_valid && in_ready;
  assign out_valid  = (r_state == S_DONE);
  assign out_data   = r_out_data;
  assign out_exp    = r_out_exp;
  assign num        = r_num;
  assign zero       = r_zero;

  // The buffer shifts left each cycle, so the chunk under test is always the top slice.
  assign w_chunk    = r_buf[BUFW-1 -: CHUNK];
  assign w_chunk_nz = |w_chunk;
  assign w_last     = (r_idx == IDXW'(NCHUNK - 1));

  always_comb begin
    w_chunk_lz = 7'(CHUNK);
    for (int i = 0; i < CHUNK; i++) begin
      if (w_chunk[i]) w_chunk_lz = 7'(CHUNK - 1 - i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept)              w_state_next = S_SCAN;
      S_SCAN: if (w_chunk_nz || w_last)  w_state_next = S_DONE;
      S_DONE: if (out_ready)             w_state_next = S_IDLE;
      default:                           w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf      <= '0;
      r_idx      <= '0;
      r_base     <= '0;
      r_num      <= '0;
      r_zero     <= 1'b0;
      r_out_data <= '0;
      r_out_exp  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_buf      <= BUFW'(in_data) << PADW;
            r_out_data <= in_data;
            r_out_exp  <= in_exp;
            r_idx      <= '0;
            r_base     <= '0;
            r_num      <= '0;
            r_zero     <= 1'b0;
          end
        end
        S_SCAN: begin
          if (w_chunk_nz) begin
            r_num  <= r_base + w_chunk_lz;
            r_zero <= 1'b0;
          end else if (w_last) begin
            // Clamp to W so LSB padding never inflates the count.
            r_num  <= 7'(W);
            r_zero <= 1'b1;
          end else begin
            r_buf  <= r_buf << CHUNK;
            r_idx  <= r_idx + 1'b1;
            r_base <= r_base + 7'(CHUNK);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lzc_scan.sv
// tb/tb_lzc_scan.sv - self-checking bench for lzc_scan
// Directed and random operands compared against a bit-scan reference of the leading-zero count.
module tb_lzc_scan;

  localparam int W      = 78;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [7:0]   in_exp;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [7:0]   out_exp;
  logic [6:0]   num;
  logic         zero;

  int checks = 0;
  int errors = 0;

  lzc_scan dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_exp   (in_exp),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_exp  (out_exp),
    .num      (num),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_lz(input logic [W-1:0] d);
    for (int b = W - 1; b >= 0; b--) begin
      if (d[b]) return W - 1 - b;
    end
    return W;
  endfunction

  function automatic int ref_latency(input int lz);
    return (lz == W) ? NCHUNK : lz / CHUNK + 1;
  endfunction

  function automatic logic [W-1:0] rand_word();
    return W'({$urandom, $urandom, $urandom});
  endfunction

  function automatic logic [W-1:0] rand_with_lz(input int k);
    logic [W-1:0] r;
    if (k >= W) return '0;
    r = rand_word() >> k;
    r[W-1-k] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] d, input logic [7:0] e, input int bp, input string tag);
    int lz, lat, n;
    logic [W-1:0] h_data;
    logic [7:0]   h_exp;
    logic [6:0]   h_num;
    logic         h_zero;
    lz = ref_lz(d);
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_in_ready_before"}, in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_exp   = e;
    tick();
    in_valid = 1'b0;
    in_data  = ~d;
    in_exp   = ~e;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, ref_latency(lz));
    check({tag, "_num"}, num, lz);
    check({tag, "_zero"}, zero, (lz == W));
    check({tag, "_out_data"}, out_data, d);
    check({tag, "_out_exp"}, out_exp, e);
    h_data = out_data;
    h_exp  = out_exp;
    h_num  = num;
    h_zero = zero;
    for (int c = 0; c < bp; c++) begin
      in_valid = (c % 2 == 0);
      in_data  = rand_word();
      in_exp   = 8'($urandom);
      tick();
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_in_ready"}, in_ready, 0);
      check({tag, "_hold_outs"}, {h_data, h_exp, h_num, h_zero}, {out_data, out_exp, num, zero});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_in_ready_after"}, in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] d;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_exp    = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_num", num, 0);
    check("reset_zero", zero, 0);
    check("reset_out_data", out_data, 0);
    rst = 1'b0;
    #1;
    check("release_in_ready", in_ready, 1);

    d = rand_word();
    d[W-1] = 1'b1;
    run_op(d, 8'h40, 0, "msb");
    d = W'(1) << 40;
    run_op(d, 8'h11, 0, "bit40");
    d = W'(1);
    run_op(d, 8'h22, 0, "bit0");
    run_op('0, 8'h33, 0, "allzero");
    d = rand_with_lz(19);
    run_op(d, 8'h5a, 4, "backpressure");
    d = rand_with_lz(3);
    run_op(d, 8'ha5, 0, "after_bp");

    // Abort a long scan in its third cycle.
    in_valid = 1'b1;
    in_data  = '0;
    in_exp   = 8'h77;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("abort_in_ready_rst", in_ready, 0);
    tick();
    check("abort_out_valid", out_valid, 0);
    check("abort_num", num, 0);
    check("abort_zero", zero, 0);
    check("abort_out_exp", out_exp, 0);
    check("abort_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check("abort_release_in_ready", in_ready, 1);
    d = W'(1) << 70;
    run_op(d, 8'h0f, 0, "post_abort");

    for (int t = 0; t < 24; t++) begin
      d = rand_with_lz(int'($urandom_range(0, W)));
      run_op(d, 8'($urandom), int'($urandom_range(0, 3)), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
